// File: rtl/timer_pkg.sv
// Shared timer definitions: register offsets, FSM states, request payload and helpers.
package timer_pkg;

  localparam int unsigned TCR_OFF    = 32'h0000_0000;
  localparam int unsigned TDR0_OFF   = 32'h0000_0004;
  localparam int unsigned TDR1_OFF   = 32'h0000_0008;
  localparam int unsigned TCR_EN_BIT = 0;
  localparam int unsigned WCNT_W     = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} timer_state_e;

  typedef enum logic [1:0] {REG_TCR, REG_TDR0, REG_TDR1, REG_NONE} timer_reg_e;

  // Access captured on the first access-phase edge and replayed at completion.
  typedef struct packed {
    logic       wr;
    timer_reg_e sel;
  } timer_req_t;

  // Map a zero-extended byte address to a register; misaligned or unknown -> REG_NONE.
  function automatic timer_reg_e decode_reg(input logic [31:0] a);
    decode_reg = REG_NONE;
    if (a == TCR_OFF)  decode_reg = REG_TCR;
    if (a == TDR0_OFF) decode_reg = REG_TDR0;
    if (a == TDR1_OFF) decode_reg = REG_TDR1;
  endfunction

  // Per-byte select of new data over the current value.
  function automatic logic [31:0] byte_merge(input logic [31:0] new_v,
                                             input logic [31:0] old_v,
                                             input logic [3:0]  strb);
    byte_merge = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) byte_merge[8*i +: 8] = new_v[8*i +: 8];
    end
  endfunction

endpackage

// File: rtl/apb_timer_regif_if.sv
// APB3 bus bundle between the interconnect (master) and the timer register file (slave).
interface apb_timer_regif_if #(
  parameter int unsigned ADDR_W = 12
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic              pready;
  logic [31:0]       prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_timer_regif.sv
// APB3 responder for the timer: wait-stated access FSM, coherent 64-bit read snapshot,
// byte-merged single-cycle write strobe towards the counter.
module apb_timer_regif
  import timer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  apb_timer_regif_if.slave    apb,
  output logic [31:0]         addr,
  output logic                wr_en,
  output logic [31:0]         wdata,
  output logic                cnt_en,
  input  logic [31:0]         tdr_0,
  input  logic [31:0]         tdr_1
);

  // First access cycle is spent in IDLE, so WAIT holds for WAIT_CYCLES-1 cycles before RESP.
  localparam int unsigned WAIT_LOAD = (WAIT_CYCLES > 1) ? WAIT_CYCLES - 2 : 0;

  timer_state_e      state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  timer_req_t        req_q, req_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       shadow_q, shadow_d;
  logic              pready_q, pready_d;
  logic [31:0]       prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cnt_en_q, cnt_en_d;

  logic [ADDR_W-1:0] paddr_w;
  logic              access;
  timer_reg_e        cur_reg;

  assign paddr_w = apb.paddr;
  assign access  = apb.psel & apb.penable;
  assign cur_reg = decode_reg(32'(paddr_w));

  // Next-state, sampling and registered-output logic.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    shadow_d  = shadow_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_en_d  = cnt_en_q;
    wr_en_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (access && !pready_q) begin
          req_d   = '{wr: apb.pwrite, sel: cur_reg};
          wcnt_d  = WCNT_W'(WAIT_LOAD);
          rdata_d = '0;
          if (!apb.pwrite) begin
            case (cur_reg)
              REG_TCR:  rdata_d[TCR_EN_BIT] = cnt_en_q;
              REG_TDR0: begin
                rdata_d  = tdr_0;
                shadow_d = tdr_1;
              end
              REG_TDR1: rdata_d = shadow_q;
              default:  rdata_d = '0;
            endcase
          end
          state_d = (WAIT_CYCLES > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else if (wcnt_q == '0) begin
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        // Write side effects land on the completing edge only.
        if (access && req_q.wr) begin
          case (req_q.sel)
            REG_TCR: begin
              if (apb.pstrb[0]) cnt_en_d = apb.pwdata[TCR_EN_BIT];
            end
            REG_TDR0: begin
              wr_en_d = 1'b1;
              addr_d  = 32'(TDR0_OFF);
              wdata_d = byte_merge(apb.pwdata, tdr_0, apb.pstrb);
            end
            REG_TDR1: begin
              wr_en_d = 1'b1;
              addr_d  = 32'(TDR1_OFF);
              wdata_d = byte_merge(apb.pwdata, tdr_1, apb.pstrb);
            end
            default: wr_en_d = 1'b0;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    pready_d  = (state_d == RESP);
    pslverr_d = pready_d && (req_d.sel == REG_NONE);
    prdata_d  = pready_d ? rdata_d : '0;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      req_q     <= '{wr: 1'b0, sel: REG_NONE};
      rdata_q   <= '0;
      shadow_q  <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      req_q     <= req_d;
      rdata_q   <= rdata_d;
      shadow_q  <= shadow_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_en_q  <= cnt_en_d;
    end
  end

  assign apb.pready  = pready_q;
  assign apb.prdata  = prdata_q;
  assign apb.pslverr = pslverr_q;
  assign addr        = addr_q;
  assign wr_en       = wr_en_q;
  assign wdata       = wdata_q;
  assign cnt_en      = cnt_en_q;

endmodule

// File: tb/tb_apb_timer_regif.sv
// Scoreboard bench for apb_timer_regif: one instance with one wait state, one with three.
module tb_apb_timer_regif;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst3;
  logic [31:0] tdr_0, tdr_1;

  // Shared master drive; m_sel steers psel to instance 1 (0) or instance 3 (1).
  logic        m_sel, m_psel, m_penable, m_pwrite;
  logic [11:0] m_paddr;
  logic [31:0] m_pwdata;
  logic [3:0]  m_pstrb;
  logic        m_pready, m_pslverr;
  logic [31:0] m_prdata;

  apb_timer_regif_if #(.ADDR_W(12)) bus1 ();
  apb_timer_regif_if #(.ADDR_W(12)) bus3 ();

  assign bus1.psel    = m_psel & ~m_sel;
  assign bus3.psel    = m_psel &  m_sel;
  assign bus1.penable = m_penable;
  assign bus3.penable = m_penable;
  assign bus1.pwrite  = m_pwrite;
  assign bus3.pwrite  = m_pwrite;
  assign bus1.paddr   = m_paddr;
  assign bus3.paddr   = m_paddr;
  assign bus1.pwdata  = m_pwdata;
  assign bus3.pwdata  = m_pwdata;
  assign bus1.pstrb   = m_pstrb;
  assign bus3.pstrb   = m_pstrb;
  assign m_pready     = m_sel ? bus3.pready  : bus1.pready;
  assign m_prdata     = m_sel ? bus3.prdata  : bus1.prdata;
  assign m_pslverr    = m_sel ? bus3.pslverr : bus1.pslverr;

  logic [31:0] addr1, wdata1, addr3, wdata3;
  logic        wr_en1, cnt_en1, wr_en3, cnt_en3;

  apb_timer_regif #(.ADDR_W(12), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .apb(bus1),
    .addr(addr1), .wr_en(wr_en1), .wdata(wdata1), .cnt_en(cnt_en1),
    .tdr_0(tdr_0), .tdr_1(tdr_1)
  );

  apb_timer_regif #(.ADDR_W(12), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .apb(bus3),
    .addr(addr3), .wr_en(wr_en3), .wdata(wdata3), .cnt_en(cnt_en3),
    .tdr_0(tdr_0), .tdr_1(tdr_1)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        is_rd;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } wexp_t;

  exp_t  exp_q[$];
  wexp_t wq1[$];
  wexp_t wq3[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int nrdy1 = 0, nrdy3 = 0, ntx1 = 0, ntx3 = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Count every pready cycle per instance; compared with completed transfers at the end.
  always @(negedge clk) begin
    nrdy1 <= nrdy1 + int'(bus1.pready);
    nrdy3 <= nrdy3 + int'(bus3.pready);
  end

  // Write-strobe scoreboards.
  always @(negedge clk) begin
    wexp_t w;
    if (wr_en1) begin
      if (wq1.size() == 0) chk("wr1_unexpected", 64'(wr_en1), 64'(0));
      else begin
        w = wq1.pop_front();
        chk("wr1_addr", 64'(addr1), 64'(w.addr));
        chk("wr1_wdata", 64'(wdata1), 64'(w.data));
        chk("wr1_cycle", 64'(cyc), 64'(w.due));
      end
    end
    if (wr_en3) begin
      if (wq3.size() == 0) chk("wr3_unexpected", 64'(wr_en3), 64'(0));
      else begin
        w = wq3.pop_front();
        chk("wr3_addr", 64'(addr3), 64'(w.addr));
        chk("wr3_wdata", 64'(wdata3), 64'(w.data));
        chk("wr3_cycle", 64'(cyc), 64'(w.due));
      end
    end
  end

  // One APB transfer; returns on the negedge of the pready cycle with the bus still held.
  task automatic xfer(input logic sel, input logic wr, input logic [11:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input logic exp_wr, input logic [31:0] exp_wd);
    exp_t  e;
    wexp_t w;
    int    n;
    logic  done;
    e.rd = exp_rd; e.err = exp_err; e.is_rd = !wr; e.lat = sel ? 4 : 2;
    exp_q.push_back(e);
    @(negedge clk);
    m_sel = sel; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr;
    m_paddr = a; m_pwdata = d; m_pstrb = s;
    @(negedge clk);
    m_penable = 1'b1;
    n = 1;
    done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (m_pready) begin
        done = 1'b1;
        e = exp_q.pop_front();
        chk("latency", 64'(n), 64'(e.lat));
        chk("pslverr", 64'(m_pslverr), 64'(e.err));
        if (e.is_rd) chk("prdata", 64'(m_prdata), 64'(e.rd));
        if (sel) ntx3++; else ntx1++;
        if (exp_wr) begin
          w.addr = 32'(a); w.data = exp_wd; w.due = cyc + 1;
          if (sel) wq3.push_back(w); else wq1.push_back(w);
        end
      end else begin
        chk("resp_idle_zero", {31'(0), m_pslverr, m_prdata}, 64'(0));
      end
    end
    if (!done) begin
      chk("pready_timeout", 64'(0), 64'(1));
      e = exp_q.pop_front();
    end
  endtask

  task automatic idle();
    @(negedge clk);
    m_psel = 1'b0;
    m_penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    m_sel = 1'b0; m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
    m_paddr = '0; m_pwdata = '0; m_pstrb = '0;
    tdr_0 = '0; tdr_1 = '0;
    repeat (3) @(negedge clk);

    chk("rst_ctrl", {60'(0), bus1.pready, bus1.pslverr, wr_en1, cnt_en1}, 64'(0));
    chk("rst_prdata", 64'(bus1.prdata), 64'(0));
    chk("rst_addr", 64'(addr1), 64'(0));
    chk("rst_wdata", 64'(wdata1), 64'(0));
    rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    // TCR enable write: cnt_en follows one cycle after completion.
    xfer(1'b0, 1'b1, 12'h000, 32'h1, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("cnt_en_before", 64'(cnt_en1), 64'(0));
    idle();
    chk("cnt_en_after", 64'(cnt_en1), 64'(1));

    // TDR writes with partial, empty and single-byte strobes (back-to-back).
    tdr_0 = 32'h1234_5678; tdr_1 = 32'hCAFE_BABE;
    xfer(1'b0, 1'b1, 12'h004, 32'hFFFF_FFF0, 4'h3, 32'h0, 1'b0, 1'b1, 32'h1234_FFF0);
    xfer(1'b0, 1'b1, 12'h008, 32'hAAAA_AAAA, 4'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE_BABE);
    xfer(1'b0, 1'b1, 12'h008, 32'h0000_0055, 4'h1, 32'h0, 1'b0, 1'b1, 32'hCAFE_BA55);
    xfer(1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 32'h1, 1'b0, 1'b0, 32'h0);

    // Coherent read across a low-word carry.
    tdr_0 = 32'hFFFF_FFFE; tdr_1 = 32'h0;
    xfer(1'b0, 1'b0, 12'h004, 32'h0, 4'h0, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
    tdr_0 = 32'h0; tdr_1 = 32'h1;
    xfer(1'b0, 1'b0, 12'h008, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    xfer(1'b0, 1'b0, 12'h004, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    xfer(1'b0, 1'b0, 12'h008, 32'h0, 4'h0, 32'h1, 1'b0, 1'b0, 32'h0);

    // Error decode: unmapped, misaligned, writes with no side effect.
    xfer(1'b0, 1'b0, 12'h00C, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    xfer(1'b0, 1'b0, 12'h006, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    xfer(1'b0, 1'b1, 12'h00C, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
    xfer(1'b0, 1'b1, 12'h005, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
    idle();
    chk("cnt_en_err_wr", 64'(cnt_en1), 64'(1));

    // TCR bit0 only follows pstrb[0].
    xfer(1'b0, 1'b1, 12'h000, 32'h0, 4'hE, 32'h0, 1'b0, 1'b0, 32'h0);
    idle();
    chk("cnt_en_nostrb", 64'(cnt_en1), 64'(1));
    xfer(1'b0, 1'b1, 12'h000, 32'h0, 4'h1, 32'h0, 1'b0, 1'b0, 32'h0);
    idle();
    chk("cnt_en_clear", 64'(cnt_en1), 64'(0));

    // Three wait states, back-to-back read then write.
    tdr_0 = 32'h0BAD_F00D; tdr_1 = 32'h1111_2222;
    xfer(1'b1, 1'b0, 12'h004, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
    xfer(1'b1, 1'b1, 12'h004, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 1'b1, 32'hA5A5_A5A5);
    xfer(1'b1, 1'b0, 12'h008, 32'h0, 4'h0, 32'h1111_2222, 1'b0, 1'b0, 32'h0);
    xfer(1'b1, 1'b1, 12'h000, 32'h1, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0);
    idle();
    chk("cnt_en3_set", 64'(cnt_en3), 64'(1));

    // Reset during the wait phase of a TDR1 write.
    @(negedge clk);
    m_sel = 1'b1; m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1;
    m_paddr = 12'h008; m_pwdata = 32'hDEAD_BEEF; m_pstrb = 4'hF;
    @(negedge clk);
    m_penable = 1'b1;
    @(negedge clk);
    chk("abort_wait_pready", 64'(bus3.pready), 64'(0));
    rst3 = 1'b1;
    #1;
    chk("rst_mid_ctrl", {61'(0), bus3.pready, wr_en3, cnt_en3}, 64'(0));
    m_psel = 1'b0; m_penable = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    repeat (4) @(negedge clk);
    xfer(1'b1, 1'b0, 12'h000, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle();
    repeat (3) @(negedge clk);

    chk("wq1_drained", 64'(wq1.size()), 64'(0));
    chk("wq3_drained", 64'(wq3.size()), 64'(0));
    chk("pready1_count", 64'(nrdy1), 64'(ntx1));
    chk("pready3_count", 64'(nrdy3), 64'(ntx3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
